// File: rtl/mem_check_pkg.sv
// mem_check_pkg: shared state encodings and default mailbox constants for mem_result_checker.
package mem_check_pkg;
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_PASS    = 3'd2,
    S_FAIL    = 3'd3,
    S_TIMEOUT = 3'd4,
    S_HANG    = 3'd5
  } state_t;
  localparam logic [31:0] DEF_TARGET_ADDR = 32'd128;
  localparam logic [31:0] DEF_PASS_DATA   = 32'd254;
  localparam logic [31:0] DEF_IGNORE_DATA = 32'd255;
endpackage

// File: rtl/mem_result_checker_sat_counter.sv
// sat_counter: synchronous-clear up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] value
);
  always_ff @(posedge clk)
    value <= clr ? '0 : (inc && !(&value)) ? value + 1'b1 : value;
endmodule

// File: rtl/mem_result_checker.sv
// mem_result_checker: watches the Memory-stage store bus for a mailbox write and latches a sticky verdict.
// Optional PC-stall hang detection is built when HANG_DETECT_EN is defined.
module mem_result_checker
  import mem_check_pkg::*;
#(
  parameter logic [31:0] TARGET_ADDR    = DEF_TARGET_ADDR,
  parameter logic [31:0] PASS_DATA      = DEF_PASS_DATA,
  parameter logic [31:0] IGNORE_DATA    = DEF_IGNORE_DATA,
  parameter int          TIMEOUT_CYCLES = 1000,
  parameter int          CNT_W          = 16,
  parameter int          HANG_CYCLES    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemWriteM,
  input  logic [31:0]      DataAdrM,
  input  logic [31:0]      WriteDataM,
  input  logic [31:0]      PCF,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [2:0]       status,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] write_count,
  output logic [31:0]      bad_data
);
  state_t r_state;
  logic   w_run, w_hit, w_pass, w_fail, w_tmo, w_hang;
  assign w_run  = r_state == S_RUN;
  assign w_hit  = w_run && MemWriteM && DataAdrM == TARGET_ADDR;
  assign w_pass = w_hit && WriteDataM == PASS_DATA;
  assign w_fail = w_hit && WriteDataM != PASS_DATA && WriteDataM != IGNORE_DATA;
  assign w_tmo  = w_run && cycle_count == CNT_W'(TIMEOUT_CYCLES - 1);
  assign status = r_state;
  sat_counter #(.WIDTH(CNT_W)) u_cycle (
    .clk(clk), .clr(reset), .inc(w_run), .value(cycle_count)
  );
  sat_counter #(.WIDTH(CNT_W)) u_write (
    .clk(clk), .clr(reset), .inc(w_run && MemWriteM), .value(write_count)
  );
`ifdef HANG_DETECT_EN
  logic [31:0]      r_last_pc;
  logic [CNT_W-1:0] w_stall_cnt;
  logic             w_same;
  assign w_same = PCF == r_last_pc;
  always_ff @(posedge clk)
    if (reset) r_last_pc <= '0;
    else if (w_run) r_last_pc <= PCF;
  sat_counter #(.WIDTH(CNT_W)) u_stall (
    .clk(clk), .clr(reset || (w_run && !w_same)), .inc(w_run && w_same), .value(w_stall_cnt)
  );
  assign w_hang = w_run && w_same && w_stall_cnt == CNT_W'(HANG_CYCLES - 1);
`else
  logic w_unused_pcf;
  assign w_unused_pcf = ^{PCF, 32'(HANG_CYCLES)};
  assign w_hang = 1'b0;
`endif
  // Verdict priority: mailbox store beats hang, hang beats timeout.
  always_ff @(posedge clk)
    if (reset) begin
      r_state  <= S_IDLE;
      done     <= 1'b0;
      pass     <= 1'b0;
      fail     <= 1'b0;
      timeout  <= 1'b0;
      bad_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_RUN;
        S_RUN:
          if (w_pass) begin
            r_state <= S_PASS;
            pass    <= 1'b1;
            done    <= 1'b1;
          end else if (w_fail) begin
            r_state  <= S_FAIL;
            fail     <= 1'b1;
            done     <= 1'b1;
            bad_data <= WriteDataM;
          end else if (w_hang) begin
            r_state <= S_HANG;
            timeout <= 1'b1;
            done    <= 1'b1;
          end else if (w_tmo) begin
            r_state <= S_TIMEOUT;
            timeout <= 1'b1;
            done    <= 1'b1;
          end
        default: r_state <= r_state;
      endcase
    end
endmodule

// File: tb/tb_mem_result_checker.sv
// tb_mem_result_checker: scoreboard bench; expected verdicts are queued when stimulus is driven.
module tb_mem_result_checker;
  localparam int TMO = 50;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemWriteM = 1'b0;
  logic [31:0] DataAdrM = '0;
  logic [31:0] WriteDataM = '0;
  logic [31:0] PCF = 32'h100;
  logic        done, pass, fail, timeout;
  logic [2:0]  status;
  logic [15:0] cycle_count, write_count;
  logic [31:0] bad_data;
  typedef struct {
    logic [2:0]  st;
    logic        p, f, t;
    logic [31:0] bad;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0, errors = 0, n_edges = 0, wrote = 0;
  logic hold_pc = 1'b0;

  mem_result_checker #(.TIMEOUT_CYCLES(TMO), .CNT_W(16), .HANG_CYCLES(32)) dut (
    .clk(clk), .reset(reset), .MemWriteM(MemWriteM), .DataAdrM(DataAdrM),
    .WriteDataM(WriteDataM), .PCF(PCF), .done(done), .pass(pass), .fail(fail),
    .timeout(timeout), .status(status), .cycle_count(cycle_count),
    .write_count(write_count), .bad_data(bad_data)
  );

  always #5 clk = ~clk;

  task automatic cyc;
    @(posedge clk);
    #1;
    n_edges++;
    if (!hold_pc) PCF = PCF + 32'd4;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    MemWriteM = 1'b1; DataAdrM = a; WriteDataM = d;
    cyc();
    MemWriteM = 1'b0;
    wrote++;
  endtask

  task automatic start;
    reset = 1'b1; MemWriteM = 1'b0;
    cyc();
    reset = 1'b0;
    cyc();
    n_edges = 0; wrote = 0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    cyc(); cyc();
    checks++;
    if ({status, done, pass, fail, timeout} !== 7'b0) begin
      errors++; $display("FAIL reset_flags got %b exp 0", {status, done, pass, fail, timeout});
    end
    checks++;
    if ({cycle_count, write_count, bad_data} !== 64'b0) begin
      errors++; $display("FAIL reset_counts got %h exp 0", {cycle_count, write_count, bad_data});
    end
  endtask

  task automatic test_pass;
    logic [15:0] cc;
    start();
    store(32'd4, 32'd1);
    store(32'd8, 32'd2);
    while (n_edges < 7) cyc();
    q.push_back('{st: 3'd2, p: 1'b1, f: 1'b0, t: 1'b0, bad: 32'd0});
    store(32'd128, 32'd254);
    e = q.pop_front();
    checks++;
    if ({status, pass, fail, timeout, done} !== {e.st, e.p, e.f, e.t, 1'b1}) begin
      errors++; $display("FAIL pass_verdict got %b exp %b", {status, pass, fail, timeout, done}, {e.st, e.p, e.f, e.t, 1'b1});
    end
    checks++;
    if (bad_data !== e.bad) begin errors++; $display("FAIL pass_bad got %h exp %h", bad_data, e.bad); end
    checks++;
    if (write_count !== 16'(wrote)) begin errors++; $display("FAIL pass_wcnt got %0d exp %0d", write_count, wrote); end
    checks++;
    if (cycle_count !== 16'(n_edges)) begin errors++; $display("FAIL pass_ccnt got %0d exp %0d", cycle_count, n_edges); end
    cc = cycle_count;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) store(32'd128, 32'd9); else cyc();
      checks++;
      if ({status, pass, fail, timeout, cycle_count, write_count} !== {3'd2, 3'b100, cc, 16'd3}) begin
        errors++; $display("FAIL pass_sticky got st %0d p%b f%b t%b cc %0d wc %0d exp st 2 cc %0d wc 3", status, pass, fail, timeout, cycle_count, write_count, cc);
      end
    end
  endtask

  task automatic test_fail;
    start();
    store(32'd128, 32'd255);
    checks++;
    if ({status, done} !== {3'd1, 1'b0}) begin errors++; $display("FAIL ignore_nov got st %0d done %b exp st 1 done 0", status, done); end
    q.push_back('{st: 3'd3, p: 1'b0, f: 1'b1, t: 1'b0, bad: 32'd7});
    store(32'd128, 32'd7);
    e = q.pop_front();
    checks++;
    if ({status, pass, fail, timeout, done} !== {e.st, e.p, e.f, e.t, 1'b1}) begin
      errors++; $display("FAIL fail_verdict got %b exp %b", {status, pass, fail, timeout, done}, {e.st, e.p, e.f, e.t, 1'b1});
    end
    checks++;
    if (bad_data !== e.bad) begin errors++; $display("FAIL fail_bad got %h exp %h", bad_data, e.bad); end
    checks++;
    if (write_count !== 16'd2) begin errors++; $display("FAIL fail_wcnt got %0d exp 2", write_count); end
  endtask

  task automatic test_timeout;
    start();
    q.push_back('{st: 3'd4, p: 1'b0, f: 1'b0, t: 1'b1, bad: 32'd0});
    for (int i = 0; i < TMO + 20 && done !== 1'b1; i++) begin
      store(32'(4 * (i % 32)), 32'(i));
      checks++;
      if (n_edges < TMO && done !== 1'b0) begin errors++; $display("FAIL tmo_early got done at edge %0d exp %0d", n_edges, TMO); end
    end
    e = q.pop_front();
    checks++;
    if ({status, pass, fail, timeout, done} !== {e.st, e.p, e.f, e.t, 1'b1}) begin
      errors++; $display("FAIL tmo_verdict got %b exp %b", {status, pass, fail, timeout, done}, {e.st, e.p, e.f, e.t, 1'b1});
    end
    checks++;
    if (cycle_count !== 16'(TMO) || n_edges != TMO) begin errors++; $display("FAIL tmo_ccnt got %0d edge %0d exp %0d", cycle_count, n_edges, TMO); end
    checks++;
    if (write_count !== 16'(wrote)) begin errors++; $display("FAIL tmo_wcnt got %0d exp %0d", write_count, wrote); end
  endtask

  task automatic test_pass_at_timeout;
    start();
    while (n_edges < TMO - 1) cyc();
    q.push_back('{st: 3'd2, p: 1'b1, f: 1'b0, t: 1'b0, bad: 32'd0});
    store(32'd128, 32'd254);
    e = q.pop_front();
    checks++;
    if ({status, pass, fail, timeout, done} !== {e.st, e.p, e.f, e.t, 1'b1}) begin
      errors++; $display("FAIL edge_prio got %b exp %b", {status, pass, fail, timeout, done}, {e.st, e.p, e.f, e.t, 1'b1});
    end
    checks++;
    if (cycle_count !== 16'(TMO)) begin errors++; $display("FAIL edge_ccnt got %0d exp %0d", cycle_count, TMO); end
  endtask

  task automatic test_reset_midrun;
    start();
    store(32'd0, 32'd1); store(32'd4, 32'd2); store(32'd128, 32'd255);
    checks++;
    if (write_count !== 16'd3) begin errors++; $display("FAIL mid_wcnt got %0d exp 3", write_count); end
    reset = 1'b1;
    cyc();
    checks++;
    if ({status, done, pass, fail, timeout, cycle_count, write_count, bad_data} !== 71'b0) begin
      errors++; $display("FAIL mid_reset got st %0d cc %0d wc %0d exp all 0", status, cycle_count, write_count);
    end
    reset = 1'b0;
    cyc();
    n_edges = 0; wrote = 0;
    checks++;
    if ({status, cycle_count} !== {3'd1, 16'd0}) begin errors++; $display("FAIL mid_restart got st %0d cc %0d exp st 1 cc 0", status, cycle_count); end
    q.push_back('{st: 3'd2, p: 1'b1, f: 1'b0, t: 1'b0, bad: 32'd0});
    store(32'd128, 32'd254);
    e = q.pop_front();
    checks++;
    if ({status, pass, fail, timeout, done, write_count} !== {e.st, e.p, e.f, e.t, 1'b1, 16'd1}) begin
      errors++; $display("FAIL mid_pass got st %0d p%b wc %0d exp st %0d p1 wc 1", status, pass, write_count, e.st);
    end
  endtask

  task automatic test_hang;
    hold_pc = 1'b1; PCF = 32'h20;
    start();
`ifdef HANG_DETECT_EN
    q.push_back('{st: 3'd5, p: 1'b0, f: 1'b0, t: 1'b1, bad: 32'd0});
`else
    q.push_back('{st: 3'd4, p: 1'b0, f: 1'b0, t: 1'b1, bad: 32'd0});
`endif
    for (int i = 0; i < TMO + 20 && done !== 1'b1; i++) cyc();
    e = q.pop_front();
    checks++;
    if ({status, pass, fail, timeout, done} !== {e.st, e.p, e.f, e.t, 1'b1}) begin
      errors++; $display("FAIL hang_verdict got %b exp %b", {status, pass, fail, timeout, done}, {e.st, e.p, e.f, e.t, 1'b1});
    end
`ifdef HANG_DETECT_EN
    checks++;
    if (n_edges < 32 || n_edges > 34) begin errors++; $display("FAIL hang_edge got %0d exp 32..34", n_edges); end
`else
    checks++;
    if (cycle_count !== 16'(TMO)) begin errors++; $display("FAIL hang_ccnt got %0d exp %0d", cycle_count, TMO); end
`endif
    hold_pc = 1'b0;
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail();
    test_timeout();
    test_pass_at_timeout();
    test_reset_midrun();
    test_hang();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
